// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, width limits and parity helper.
// Used by uart_rx (and its sampler) and by the paired transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 8;

  // Parity bit for a zero-extended word: even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(
    input logic [DATA_WIDTH_MAX-1:0] data,
    input logic                      odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: RX synchronizer, per-bit edge counter and bit sampler.
// Ports: clk, rst (sync, active-high), rx_in (async line), run (count
//   enable for the next cycle), rx_s (synchronized line), sample (bit
//   value, valid from sample_done to bit_done), sample_done (last sample
//   point), bit_done (last cycle of the bit).
// Build option UART_RX_MAJORITY_EN: 3-sample majority vote around mid-bit;
//   otherwise a single mid-bit sample with identical strobe timing.
module uart_rx_sampler #(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic run,
  output logic rx_s,
  output logic sample,
  output logic sample_done,
  output logic bit_done
);

  localparam int EC_W = $clog2(PRESCALE);
  localparam logic [EC_W-1:0] EC_LAST = EC_W'(PRESCALE - 1);
  localparam logic [EC_W-1:0] EC_MID  = EC_W'(PRESCALE / 2);
  localparam logic [EC_W-1:0] EC_POST = EC_W'(PRESCALE / 2 + 1);

  logic [1:0]      sync;
  logic [EC_W-1:0] ec;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx_in};
    end
  end

  // Counter follows the FSM: it only advances while a frame is (or is
  // about to be) in progress, so the start-detect cycle is ec = 0.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      ec <= '0;
    end else if (ec == EC_LAST) begin
      ec <= '0;
    end else begin
      ec <= ec + 1'b1;
    end
  end

  assign sample_done = (ec == EC_POST);
  assign bit_done    = (ec == EC_LAST);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [EC_W-1:0] EC_PRE = EC_W'(PRESCALE / 2 - 1);

  logic s_pre;
  logic s_mid;
  logic vote;
  logic vote_q;

  assign vote = (s_pre & s_mid) | (s_pre & rx_s) | (s_mid & rx_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_pre  <= 1'b1;
      s_mid  <= 1'b1;
      vote_q <= 1'b1;
    end else begin
      if (ec == EC_PRE) s_pre <= rx_s;
      if (ec == EC_MID) s_mid <= rx_s;
      if (sample_done)  vote_q <= vote;
    end
  end

  // Third vote is live at sample_done; hold it for the rest of the bit.
  assign sample = sample_done ? vote : vote_q;
`else
  logic s_mid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_mid <= 1'b1;
    end else if (ec == EC_MID) begin
      s_mid <= rx_s;
    end
  end

  assign sample = s_mid;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, LSB first, optional even/odd parity, 1 stop bit.
// Ports: CLK, RST (sync, active-high), RX_IN, PAR_EN, PAR_TYP -> P_DATA,
//   DATA_VALID / PAR_ERR / STP_ERR (1-cycle pulses), Busy. Option macro:
//   UART_RX_MAJORITY_EN selects 3-sample majority voting in the sampler.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  Busy
);

  localparam int BC_W = $clog2(DATA_WIDTH);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_WIDTH - 1);

  rx_state_e state;
  rx_state_e next_state;

  logic rx_s;
  logic sample;
  logic sample_done;
  logic bit_done;
  logic run;

  logic [BC_W-1:0]       bc;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bad;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk        (CLK),
    .rst        (RST),
    .rx_in      (RX_IN),
    .run        (run),
    .rx_s       (rx_s),
    .sample     (sample),
    .sample_done(sample_done),
    .bit_done   (bit_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (!rx_s) next_state = START;
      end
      START: begin
        if (bit_done) next_state = sample ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done && bc == BC_LAST) begin
          next_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) next_state = STOP;
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (sample_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Edge counter clears whenever the FSM is (about to be) idle.
  assign run  = (next_state != IDLE);
  assign Busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      bc         <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad    <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_bad   <= 1'b0;
            bc        <= '0;
          end
        end
        DATA: begin
          if (sample_done) shreg[bc] <= sample;
          if (bit_done && bc != BC_LAST) bc <= bc + 1'b1;
        end
        PARITY: begin
          if (sample_done &&
              sample != parity_bit(DATA_WIDTH_MAX'(shreg),
                                   par_typ_q)) begin
            par_bad <= 1'b1;
          end
        end
        STOP: begin
          if (sample_done) begin
            if (!sample) begin
              STP_ERR <= 1'b1;
            end else if (par_bad) begin
              PAR_ERR <= 1'b1;
            end else begin
              DATA_VALID <= 1'b1;
              P_DATA     <= shreg;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table + random frames against a frame-level model.
// Outcome pulses are scoreboarded by kind, P_DATA and cycle of arrival.
module tb_uart_rx;

  localparam int DW = 8;
  localparam int P  = 8;
  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_PAR   = 3'b010;
  localparam logic [2:0] K_STP   = 3'b100;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic          par_en;
  logic          par_typ;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH(DW),
    .PRESCALE  (P)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX_IN     (rx_in),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .P_DATA    (p_data),
    .DATA_VALID(data_valid),
    .PAR_ERR   (par_err),
    .STP_ERR   (stp_err),
    .Busy      (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]    kind;
    logic [DW-1:0] data;
    int            cyc;
  } ev_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          pt;
    logic          flip;
    logic          stop_ok;
    logic [2:0]    kind;
    logic [DW-1:0] exp_d;
    int            gap;
  } vec_t;

  ev_t  act_q[$];
  ev_t  exp_q[$];
  vec_t tbl[10];

  int   checks = 0;
  int   errors = 0;
  int   busy_rise = -1;
  int   busy_fall = -1;
  logic busy_prev = 1'b0;
  logic [DW-1:0] last_good = '0;

  always @(negedge clk) begin
    if (data_valid | par_err | stp_err)
      act_q.push_back('{{stp_err, par_err, data_valid}, p_data, cyc});
    if (busy === 1'b1 && !busy_prev) busy_rise = cyc;
    if (busy === 1'b0 && busy_prev) busy_fall = cyc;
    busy_prev = (busy === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; a stop-error frame holds the line low only across
  // the stop-bit sample window so no spurious start follows.
  task automatic send_frame(input logic [DW-1:0] d, input logic pe,
                            input logic pt, input logic flip,
                            input logic stop_ok, input int noise_bit,
                            output int n0);
    logic [DW+2:0] fr;
    logic          v;
    int            nb;
    nb = 2 + DW + int'(pe);
    fr = '0;
    for (int i = 0; i < DW; i++) fr[1+i] = d[i];
    if (pe) fr[DW+1] = (^d) ^ pt ^ flip;
    fr[nb-1] = 1'b1;
    par_en  = pe;
    par_typ = pt;
    n0 = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < P; c++) begin
        v = fr[b];
        if (b == nb - 1 && !stop_ok) v = (c < P / 2 + 2) ? 1'b0 : 1'b1;
        if (b == noise_bit && c == P / 2) v = ~v;
        rx_in = v;
        tick(1);
      end
    end
  endtask

  function automatic int pulse_cyc(input int n0, input logic pe);
    return n0 + 2 + (1 + DW + int'(pe)) * P + P / 2 + 2;
  endfunction

  // Frame-level reference: stop bit first, then parity rule, else data.
  task automatic model_frame(input logic [DW-1:0] d, input logic pe,
                             input logic pt, input logic flip,
                             input logic stop_ok, input int n0);
    logic       line_par;
    logic [2:0] k;
    line_par = (^d) ^ pt ^ flip;
    if (!stop_ok) k = K_STP;
    else if (pe && line_par != ((^d) ^ pt)) k = K_PAR;
    else k = K_VALID;
    if (k == K_VALID) last_good = d;
    exp_q.push_back('{k, last_good, pulse_cyc(n0, pe)});
  endtask

  initial begin
    int n0;
    ev_t a;
    ev_t e;
    int  idx;

    tbl[0] = '{8'h2B, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 8'h2B, 8};
    tbl[1] = '{8'h2A, 1'b1, 1'b0, 1'b0, 1'b1, K_VALID, 8'h2A, 2};
    tbl[2] = '{8'h2A, 1'b1, 1'b0, 1'b1, 1'b1, K_PAR,   8'h2A, 2};
    tbl[3] = '{8'h2B, 1'b1, 1'b1, 1'b0, 1'b1, K_VALID, 8'h2B, 2};
    tbl[4] = '{8'h2B, 1'b1, 1'b1, 1'b1, 1'b0, K_STP,   8'h2B, 2};
    tbl[5] = '{8'h2A, 1'b1, 1'b0, 1'b0, 1'b1, K_VALID, 8'h2A, 0};
    tbl[6] = '{8'hB9, 1'b1, 1'b0, 1'b0, 1'b1, K_VALID, 8'hB9, 0};
    tbl[7] = '{8'h24, 1'b1, 1'b0, 1'b0, 1'b1, K_VALID, 8'h24, 0};
    tbl[8] = '{8'hF1, 1'b1, 1'b0, 1'b0, 1'b1, K_VALID, 8'hF1, 0};
    tbl[9] = '{8'h32, 1'b1, 1'b0, 1'b0, 1'b1, K_VALID, 8'h32, 4};

    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0;
    tick(4);
    check("reset_p_data", 32'(p_data), 0);
    check("reset_valid", 32'(data_valid), 0);
    check("reset_par_err", 32'(par_err), 0);
    check("reset_stp_err", 32'(stp_err), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    tick(4);

    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].flip,
                 tbl[i].stop_ok, -1, n0);
      if (tbl[i].kind == K_VALID) last_good = tbl[i].exp_d;
      exp_q.push_back('{tbl[i].kind, tbl[i].exp_d,
                        pulse_cyc(n0, tbl[i].pe)});
      tick(tbl[i].gap);
      if (i == 0) begin
        check("busy_rise", 32'(busy_rise), 32'(n0 + 3));
        check("busy_fall", 32'(busy_fall), 32'(n0 + 80));
      end
    end

    rx_in = 1'b0;
    tick(3);
    rx_in = 1'b1;
    tick(3 * P);
    check("glitch_busy", 32'(busy), 0);
    check("glitch_p_data", 32'(p_data), 32'(last_good));

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'hA7, 1'b0, 1'b0, 1'b0, 1'b1, 3, n0);
    model_frame(8'hA7, 1'b0, 1'b0, 1'b0, 1'b1, n0);
    tick(4);
`endif

    rx_in = 1'b0;
    tick(P);
    rx_in = 1'b1;
    tick(3 * P);
    rst = 1'b1;
    tick(2);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_p_data", 32'(p_data), 0);
    last_good = '0;
    rst = 1'b0;
    tick(2 * P);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, n0);
    model_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, n0);
    tick(3);

    for (int i = 0; i < 30; i++) begin
      logic [DW-1:0] d;
      logic pe, pt, fl, so;
      d  = DW'($urandom);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 3) == 0);
      so = ($urandom_range(0, 4) != 0);
      send_frame(d, pe, pt, fl, so, -1, n0);
      model_frame(d, pe, pt, fl, so, n0);
      tick($urandom_range(0, 2));
    end

    rx_in = 1'b1;
    tick(3 * P);

    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (act_q.size() == 0) begin
        check($sformatf("missing_pulse_%0d", idx), 32'(0), 32'(1));
      end else begin
        a = act_q.pop_front();
        check($sformatf("kind_%0d", idx), 32'(a.kind), 32'(e.kind));
        check($sformatf("data_%0d", idx), 32'(a.data), 32'(e.data));
        check($sformatf("cycle_%0d", idx), 32'(a.cyc), 32'(e.cyc));
      end
      idx++;
    end
    check("extra_pulses", 32'(act_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
